morse_tx_q: RTL and testbench
=============================

// Module: morse_tx_q
// PURPOSE
//  Parametrised Morse-code LED transmitter, successor to the fixed dassign3 encoder.
//  Accepts per-character (code, length) pairs through a ready/valid port into an
//  internal FIFO, so a producer can queue DEPTH characters ahead.
//  Keys led_drv with programmable unit timing and signals each completed character.
//  Sits between the ASCII->Morse table lookup and the LED pad driver.
// PARAMETERS
//  CODE_W    8  max symbols per character; code bit [CODE_W-1] is sent first
//  LEN_W     4  width of length field; must satisfy 2**LEN_W > CODE_W
//  DEPTH     4  character FIFO entries (power of 2, >=2)
//  UNIT_DIV  1  clock cycles per Morse time unit (>=1)
//  DOT_U     1  dot mark length, units
//  DASH_U    3  dash mark length, units
//  SYM_GAP   1  gap between symbols of one character, units
//  CHAR_GAP  3  gap after the last symbol of a character, units
//  WORD_GAP  7  total word gap; a space character idles (WORD_GAP-CHAR_GAP) units
// PORTS
//  clock      in   1              rising-edge clock
//  reset      in   1              synchronous, ACTIVE-LOW (0 = reset)
//  char_vald  in   1              input character valid
//  char_rdy   out  1              FIFO can accept (= !full)
//  charcode   in   CODE_W         symbols, MSB first, 1 = dash, 0 = dot
//  charlen    in   LEN_W          symbol count; 0 = word space
//  flush      in   1              abort the current character and empty the FIFO
//  led_drv    out  1              LED on (registered)
//  char_next  out  1              1-cycle pulse: a character or space has finished
//  busy       out  1              FSM not IDLE or FIFO not empty
//  level      out  $clog2(DEPTH)+1  FIFO occupancy
// BEHAVIOUR
//  Reset (reset==0 at a clock edge):
//   - state=IDLE; FIFO emptied.
//   - led_drv=0, char_next=0, busy=0, level=0, char_rdy=1.
//   - Reset overrides everything mid-character; the aborted character produces no char_next.
//  Push / pop:
//   - Push occurs when char_vald&&char_rdy. A pushed entry is visible to the FSM the next cycle.
//   - Pushing while full is impossible (char_rdy=0); the producer holds its data.
//   - A pop and a push in the same cycle are both honoured; level is unchanged.
//   - A charlen greater than CODE_W is clamped to CODE_W.
//  Unit timer:
//   - A phase of N units lasts N*UNIT_DIV cycles.
//   - The timer restarts at the start of every phase.
//  FSM states: IDLE, MARK, SGAP, CGAP, WGAP.
//   - IDLE: if the FIFO is non-empty, pop and latch code/len/sym_idx=0.
//     len>0 -> MARK; len==0 -> WGAP.
//   - MARK: led_drv=1 for DOT_U or DASH_U units, chosen by code[CODE_W-1-sym_idx].
//     On expiry: if it was the last symbol -> CGAP, else SGAP with sym_idx+1.
//   - SGAP: LED off SYM_GAP units -> MARK.
//   - CGAP: LED off CHAR_GAP units. WGAP: LED off (WORD_GAP-CHAR_GAP) units.
//   - On CGAP/WGAP expiry: assert char_next next cycle. If the FIFO is non-empty, pop
//     in the expiry cycle and go straight to MARK/WGAP (back-to-back, no extra blank);
//     otherwise go to IDLE.
//  Latency and registering:
//   - led_drv and char_next are registered: led_drv rises in the cycle after the pop.
//   - Per-character LED pattern (UNIT_DIV=1, defaults): marks 1 or 3 cycles, 1 blank between
//     symbols, 3 blanks after the character, then the char_next pulse.
//   - A space that directly follows a character gives 7 blanks in total.
//   - A space issued from IDLE gives only 4 blanks.
//  flush (higher priority than push/pop, lower than reset):
//   - Next cycle: FIFO empty, state=IDLE, led_drv=0, no char_next.
//   - A char_vald in the flush cycle is dropped.
// TESTING
//  - 'E' (code 0x00, len 1): led 1 cyc high, 3 low, char_next pulse; busy drops after.
//  - 'A' (0x40, len 2) then 'M' (0xC0, len 2) queued back-to-back:
//    led 1,0,111,000,111,0,111,000; two char_next pulses; no idle gap between the characters.
//  - 'T' (0x80, len 1) then space (len 0): 3 high, then 7 low before the second char_next.
//  - DEPTH=4, push 6 characters while busy: char_rdy=0 after the 4th accepted push.
//    level tracks 4 -> 3 on each pop; all 6 characters are sent, in order.
//  - UNIT_DIV=4: dash = 12 cycles high, inter-symbol gap = 4 cycles low.
//  - flush in the 2nd cycle of a dash, and separately reset=0 mid-dash:
//    led_drv=0 next cycle, level=0, no char_next, and the next push transmits cleanly.

Source files
------------

// File: rtl/morse_tx_q.sv
// Morse-code LED keyer with a ready/valid character FIFO.
// Each queued (code, len) pair is keyed MSB first with programmable unit timing.
module morse_tx_q #(
    parameter int CODE_W   = 8,
    parameter int LEN_W    = 4,
    parameter int DEPTH    = 4,
    parameter int UNIT_DIV = 1,
    parameter int DOT_U    = 1,
    parameter int DASH_U   = 3,
    parameter int SYM_GAP  = 1,
    parameter int CHAR_GAP = 3,
    parameter int WORD_GAP = 7
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic                   char_vald,
    output logic                   char_rdy,
    input  logic [CODE_W-1:0]      charcode,
    input  logic [LEN_W-1:0]       charlen,
    input  logic                   flush,
    output logic                   led_drv,
    output logic                   char_next,
    output logic                   busy,
    output logic [$clog2(DEPTH):0] level
);

    localparam int PW   = $clog2(DEPTH);
    localparam int MAXU = DOT_U + DASH_U + SYM_GAP + CHAR_GAP + WORD_GAP;
    localparam int TW   = $clog2(MAXU * UNIT_DIV + 1);

    typedef enum logic [2:0] {IDLE, MARK, SGAP, CGAP, WGAP} state_t;
    state_t state, state_n;

    logic [CODE_W-1:0] code_mem [DEPTH];
    logic [LEN_W-1:0]  len_mem  [DEPTH];
    logic [PW-1:0]     wr_ptr, rd_ptr;
    logic [PW:0]       count;

    logic [CODE_W-1:0] code_q;
    logic [LEN_W-1:0]  len_q, sym_idx, len_clamp, head_len;
    logic [TW-1:0]     cnt, dur;
    logic              push, pop, expire, done, last_sym, empty;

    assign empty     = (count == '0);
    assign char_rdy  = (count != (PW+1)'(DEPTH));
    assign push      = char_vald && char_rdy && !flush;
    assign len_clamp = (charlen > LEN_W'(CODE_W)) ? LEN_W'(CODE_W) : charlen;
    assign head_len  = len_mem[rd_ptr];
    assign last_sym  = ((sym_idx + LEN_W'(1)) == len_q);
    assign busy      = (state != IDLE) || !empty;
    assign level     = count;

    always_ff @(posedge clock) begin
        if (push) begin
            code_mem[wr_ptr] <= charcode;
            len_mem[wr_ptr]  <= len_clamp;
        end
    end

    always_ff @(posedge clock) begin
        if (!reset || flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PW'(1);
            if (pop)  rd_ptr <= rd_ptr + PW'(1);
            count <= count + (PW+1)'(push) - (PW+1)'(pop);
        end
    end

    // code_q shifts left per symbol, so the active symbol is always its MSB
    always_comb begin
        dur = TW'(UNIT_DIV);
        case (state)
            MARK:    dur = code_q[CODE_W-1] ? TW'(DASH_U * UNIT_DIV)
                                            : TW'(DOT_U * UNIT_DIV);
            SGAP:    dur = TW'(SYM_GAP * UNIT_DIV);
            CGAP:    dur = TW'(CHAR_GAP * UNIT_DIV);
            WGAP:    dur = TW'((WORD_GAP - CHAR_GAP) * UNIT_DIV);
            default: dur = TW'(UNIT_DIV);
        endcase
    end

    assign expire = (state != IDLE) && (cnt == dur - TW'(1));

    always_comb begin
        state_n = state;
        pop     = 1'b0;
        done    = 1'b0;
        case (state)
            IDLE: begin
                if (!empty) begin
                    pop     = 1'b1;
                    state_n = (head_len == '0) ? WGAP : MARK;
                end
            end
            MARK: if (expire) state_n = last_sym ? CGAP : SGAP;
            SGAP: if (expire) state_n = MARK;
            CGAP, WGAP: begin
                if (expire) begin
                    done = 1'b1;
                    if (!empty) begin
                        pop     = 1'b1;
                        state_n = (head_len == '0) ? WGAP : MARK;
                    end else begin
                        state_n = IDLE;
                    end
                end
            end
            default: state_n = IDLE;
        endcase
        if (flush) begin
            state_n = IDLE;
            pop     = 1'b0;
            done    = 1'b0;
        end
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            state     <= IDLE;
            cnt       <= '0;
            code_q    <= '0;
            len_q     <= '0;
            sym_idx   <= '0;
            led_drv   <= 1'b0;
            char_next <= 1'b0;
        end else begin
            state     <= state_n;
            led_drv   <= (state_n == MARK);
            char_next <= done;
            cnt       <= (expire || state == IDLE || flush) ? '0 : cnt + TW'(1);
            if (pop) begin
                code_q  <= code_mem[rd_ptr];
                len_q   <= head_len;
                sym_idx <= '0;
            end else if (state == MARK && expire && !flush) begin
                code_q  <= code_q << 1;
                sym_idx <= sym_idx + LEN_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_morse_tx_q.sv
// Bench for morse_tx_q: decodes the LED stream back into characters and
// compares against a queue of expected characters, plus waveform corner cases.
module tb_morse_tx_q;

    typedef struct {
        logic [7:0] code;
        logic [3:0] len;
        logic [7:0] exp_code;
        int         exp_len;
        int         exp_high;
    } vec_t;

    logic       clock = 1'b0;
    logic       reset = 1'b0;
    logic       char_vald = 1'b0;
    logic [7:0] charcode = '0;
    logic [3:0] charlen = '0;
    logic       flush = 1'b0;
    logic       char_rdy, led_drv, char_next, busy;
    logic [2:0] level;

    logic       v4 = 1'b0;
    logic [7:0] c4 = '0;
    logic [3:0] l4 = '0;
    logic       f4 = 1'b0;
    logic       rdy4, led4, cn4, busy4;
    logic [2:0] lvl4;

    int checks = 0;
    int errors = 0;

    vec_t sbq[$];
    vec_t tbl[12];
    bit   mon_en = 1'b0;
    int   run, low, hi, dec_len;
    logic [7:0] dec_code;

    always #5 clock = ~clock;

    morse_tx_q dut (
        .clock(clock), .reset(reset), .char_vald(char_vald), .char_rdy(char_rdy),
        .charcode(charcode), .charlen(charlen), .flush(flush), .led_drv(led_drv),
        .char_next(char_next), .busy(busy), .level(level)
    );

    morse_tx_q #(.UNIT_DIV(4)) dut4 (
        .clock(clock), .reset(reset), .char_vald(v4), .char_rdy(rdy4),
        .charcode(c4), .charlen(l4), .flush(f4), .led_drv(led4),
        .char_next(cn4), .busy(busy4), .level(lvl4)
    );

    task automatic chk(input bit ok, input string nm, input longint act, input longint exp);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d", nm, act, exp);
        end
    endtask

    // LED decoder: rebuilds each character from mark lengths
    always @(negedge clock) begin
        vec_t e;
        if (!mon_en) begin
            run = 0; low = 0; hi = 0; dec_len = 0; dec_code = '0;
        end else begin
            if (char_next) begin
                if (sbq.size() == 0) begin
                    chk(1'b0, "unexpected_char_next", 1, 0);
                end else begin
                    e = sbq.pop_front();
                    chk(dec_len == e.exp_len, "char_len", dec_len, e.exp_len);
                    chk(dec_code == e.exp_code, "char_code", dec_code, e.exp_code);
                    chk(hi == e.exp_high, "char_high_cycles", hi, e.exp_high);
                    if (e.exp_len > 0)
                        chk(low == 3, "char_gap", low, 3);
                end
                dec_len = 0; dec_code = '0; hi = 0; low = 0;
            end
            if (led_drv) begin
                if (run == 0 && dec_len > 0)
                    chk(low == 1, "sym_gap", low, 1);
                run++; hi++; low = 0;
            end else begin
                if (run > 0) begin
                    chk(run == 1 || run == 3, "mark_len", run, 3);
                    if (dec_len < 8) dec_code[7-dec_len] = (run == 3);
                    dec_len++;
                    run = 0;
                end
                low++;
            end
        end
    end

    task automatic push(input vec_t v);
        int n = 0;
        char_vald = 1'b1;
        charcode  = v.code;
        charlen   = v.len;
        while (!char_rdy && n < 2000) begin
            @(posedge clock); #1;
            n++;
        end
        if (n >= 2000) begin
            chk(1'b0, "push_timeout", n, 2000);
        end else begin
            sbq.push_back(v);
            @(posedge clock); #1;
        end
        char_vald = 1'b0;
    endtask

    task automatic wait_idle();
        int n = 0;
        while ((busy || sbq.size() != 0) && n < 5000) begin
            @(negedge clock); #1;
            n++;
        end
        chk(n < 5000, "idle_timeout", n, 5000);
    endtask

    task automatic rec(input int n, output logic [31:0] lw, output logic [31:0] cw,
                       output logic [31:0] bw);
        lw = '0; cw = '0; bw = '0;
        for (int i = 0; i < n; i++) begin
            @(negedge clock);
            lw = {lw[30:0], led_drv};
            cw = {cw[30:0], char_next};
            bw = {bw[30:0], busy};
        end
    endtask

    initial begin
        logic [31:0] lw, cw, bw;
        int n, cn_seen, led_seen, k;
        int seg[8];
        logic cur;

        tbl[0]  = '{8'h00, 4'd1,  8'h00, 1, 1};
        tbl[1]  = '{8'h40, 4'd2,  8'h40, 2, 4};
        tbl[2]  = '{8'hC0, 4'd2,  8'hC0, 2, 6};
        tbl[3]  = '{8'h80, 4'd1,  8'h80, 1, 3};
        tbl[4]  = '{8'h00, 4'd0,  8'h00, 0, 0};
        tbl[5]  = '{8'h9F, 4'd2,  8'h80, 2, 4};
        tbl[6]  = '{8'hFF, 4'd12, 8'hFF, 8, 24};
        tbl[7]  = '{8'hE0, 4'd3,  8'hE0, 3, 9};
        tbl[8]  = '{8'h00, 4'd0,  8'h00, 0, 0};
        tbl[9]  = '{8'hA5, 4'd8,  8'hA5, 8, 16};
        tbl[10] = '{8'hFF, 4'd8,  8'hFF, 8, 24};
        tbl[11] = '{8'h00, 4'd15, 8'h00, 8, 8};

        repeat (3) @(posedge clock);
        @(negedge clock);
        chk(led_drv == 1'b0, "rst_led", led_drv, 0);
        chk(char_next == 1'b0, "rst_char_next", char_next, 0);
        chk(busy == 1'b0, "rst_busy", busy, 0);
        chk(level == 3'd0, "rst_level", level, 0);
        chk(char_rdy == 1'b1, "rst_rdy", char_rdy, 1);
        reset = 1'b1;
        mon_en = 1'b1;
        @(negedge clock); #1;

        for (int i = 0; i < 12; i++) push(tbl[i]);
        wait_idle();

        push(tbl[0]);
        rec(6, lw, cw, bw);
        chk(lw[5:0] == 6'b010000, "e_led", lw[5:0], 6'b010000);
        chk(cw[5:0] == 6'b000001, "e_next", cw[5:0], 6'b000001);
        chk(bw[5:0] == 6'b111110, "e_busy", bw[5:0], 6'b111110);
        wait_idle();

        push(tbl[1]);
        push(tbl[2]);
        rec(19, lw, cw, bw);
        chk(lw[18:0] == 19'b1011100011101110000, "am_led", lw[18:0], 19'b1011100011101110000);
        chk(cw[18:0] == 19'b0000000010000000001, "am_next", cw[18:0], 19'b0000000010000000001);
        wait_idle();

        push(tbl[3]);
        push(tbl[4]);
        rec(11, lw, cw, bw);
        chk(lw[10:0] == 11'b11100000000, "tsp_led", lw[10:0], 11'b11100000000);
        chk(cw[10:0] == 11'b00000010001, "tsp_next", cw[10:0], 11'b00000010001);
        wait_idle();

        push(tbl[4]);
        rec(6, lw, cw, bw);
        chk(lw[5:0] == 6'b000000, "sp_led", lw[5:0], 0);
        chk(cw[5:0] == 6'b000001, "sp_next", cw[5:0], 6'b000001);
        wait_idle();

        push(tbl[7]);
        push(tbl[1]);
        push(tbl[2]);
        push(tbl[3]);
        push(tbl[5]);
        chk(char_rdy == 1'b0, "full_rdy", char_rdy, 0);
        chk(level == 3'd4, "full_level", level, 4);
        n = 0;
        while (level == 3'd4 && n < 300) begin
            @(negedge clock);
            n++;
        end
        chk(level == 3'd3, "pop_level", level, 3);
        chk(char_next == 1'b1, "pop_with_next", char_next, 1);
        @(posedge clock); #1;
        push(tbl[9]);
        push(tbl[0]);
        wait_idle();

        mon_en = 1'b0;
        push(tbl[3]);
        push(tbl[0]);
        sbq.delete();
        @(posedge clock); #1;
        chk(led_drv == 1'b1, "fl_mid_dash", led_drv, 1);
        flush = 1'b1;
        char_vald = 1'b1; charcode = 8'hE0; charlen = 4'd3;
        @(posedge clock); #1;
        flush = 1'b0; char_vald = 1'b0;
        @(negedge clock);
        chk(led_drv == 1'b0, "fl_led", led_drv, 0);
        chk(level == 3'd0, "fl_level", level, 0);
        chk(busy == 1'b0, "fl_busy", busy, 0);
        chk(char_next == 1'b0, "fl_next", char_next, 0);
        cn_seen = 0; led_seen = 0;
        repeat (10) begin
            @(negedge clock);
            if (char_next) cn_seen++;
            if (led_drv) led_seen++;
        end
        chk(cn_seen == 0, "fl_no_next", cn_seen, 0);
        chk(led_seen == 0, "fl_quiet", led_seen, 0);
        #1;
        mon_en = 1'b1;
        push(tbl[7]);
        wait_idle();

        mon_en = 1'b0;
        push(tbl[3]);
        push(tbl[0]);
        sbq.delete();
        @(posedge clock); #1;
        chk(led_drv == 1'b1, "rs_mid_dash", led_drv, 1);
        reset = 1'b0;
        @(posedge clock); #1;
        reset = 1'b1;
        @(negedge clock);
        chk(led_drv == 1'b0, "rs_led", led_drv, 0);
        chk(level == 3'd0, "rs_level", level, 0);
        chk(char_rdy == 1'b1, "rs_rdy", char_rdy, 1);
        chk(char_next == 1'b0, "rs_next", char_next, 0);
        cn_seen = 0;
        repeat (10) begin
            @(negedge clock);
            if (char_next) cn_seen++;
        end
        chk(cn_seen == 0, "rs_no_next", cn_seen, 0);
        #1;
        mon_en = 1'b1;
        push(tbl[1]);
        wait_idle();

        v4 = 1'b1; c4 = 8'h40; l4 = 4'd2;
        @(posedge clock); #1;
        v4 = 1'b0;
        for (int i = 0; i < 8; i++) seg[i] = 0;
        k = 0; cur = 1'b0; n = 0;
        while (n < 200) begin
            @(negedge clock);
            n++;
            if (cn4) break;
            if (led4 != cur) begin
                if (k < 7) k++;
                cur = led4;
            end
            seg[k]++;
        end
        chk(n < 200, "ud4_timeout", n, 200);
        chk(k == 4, "ud4_segments", k, 4);
        chk(seg[1] == 4, "ud4_dot", seg[1], 4);
        chk(seg[2] == 4, "ud4_sym_gap", seg[2], 4);
        chk(seg[3] == 12, "ud4_dash", seg[3], 12);
        chk(seg[4] == 12, "ud4_char_gap", seg[4], 12);
        @(negedge clock);
        chk(busy4 == 1'b0, "ud4_busy", busy4, 0);
        chk(lvl4 == 3'd0, "ud4_level", lvl4, 0);
        chk(rdy4 == 1'b1, "ud4_rdy", rdy4, 1);

        chk(sbq.size() == 0, "sb_empty", sbq.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
